// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and the
// default bit period used by both the send and receive paths.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  // 10416 clocks per bit = 9600 baud from a 100 MHz board clock.
  localparam logic [31:0] CLKS_PER_BIT_DEFAULT = 32'h28B0;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchroniser for asynchronous single-bit inputs (serial line,
// buttons). Both stages reset to 1 so an idle-high line reads idle at once.
module rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back capture stages to settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_receive.sv
// UART receiver, 8 data bits, LSB first, one stop bit.
// Optional feature macro: UART_RX_PARITY_EN adds one even-parity bit between
// the data bits and the stop bit; parity_error then pulses alongside valid.
// Without the macro the frame is plain 8N1 and parity_error is tied low.
module uart_receive
  import uart_pkg::*;
#(
  parameter logic [31:0] CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 UART_RX,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 busy,
  output logic                 frame_error,
  output logic                 parity_error
);

  localparam logic [31:0] HALF_M1 = CLKS_PER_BIT / 2 - 32'd1;
  localparam logic [31:0] FULL_M1 = CLKS_PER_BIT - 32'd1;
  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

  logic rx_s;

  rx_sync u_rx_sync (
    .clk   (CLK),
    .rst_n (RESET),
    .d     (UART_RX),
    .q     (rx_s)
  );

  rx_state_t            state_q, state_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 frame_error_q, frame_error_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_err_q, par_err_d;
  logic                 parity_error_q, parity_error_d;
`endif

  // Next-state logic: bit timing, sampling and one-cycle status pulses.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + 32'd1;
    bit_idx_d     = bit_idx_q;
    shreg_d       = shreg_q;
    data_d        = data_q;
    valid_d       = 1'b0;
    busy_d        = busy_q;
    frame_error_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d      = par_err_q;
    parity_error_d = 1'b0;
`endif
    unique case (state_q)
      WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      IDLE: begin
        cnt_d  = '0;
        busy_d = 1'b0;
        if (!rx_s) begin
          state_d = START;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            bit_idx_d = '0;
            state_d   = DATA;
          end
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d            = '0;
          shreg_d[bit_idx_q] = rx_s;
          bit_idx_d        = bit_idx_q + 3'd1;
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          par_err_d = rx_s ^ (^shreg_q);
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d  = '0;
          busy_d = 1'b0;
          if (rx_s) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_error_d = par_err_q;
`endif
            state_d = IDLE;
          end else begin
            frame_error_d = 1'b1;
            state_d       = WAIT_IDLE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        busy_d  = 1'b0;
        state_d = WAIT_IDLE;
      end
    endcase
  end

  // Receiver state and registered outputs; reset discards any partial byte.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= WAIT_IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shreg_q       <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      frame_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q      <= 1'b0;
      parity_error_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shreg_q       <= shreg_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      busy_q        <= busy_d;
      frame_error_q <= frame_error_d;
`ifdef UART_RX_PARITY_EN
      par_err_q      <= par_err_d;
      parity_error_q <= parity_error_d;
`endif
    end
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign busy        = busy_q;
  assign frame_error = frame_error_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error = parity_error_q;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receive.sv
// Self-checking bench for uart_receive at 16 clocks per bit. Expected bytes
// are queued as frames are driven and checked when valid pulses.
module tb_uart_receive;

  localparam int unsigned CPB     = 16;
  localparam int unsigned LATENCY = 3 + CPB / 2 + 9 * CPB;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       UART_RX = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       busy;
  logic       frame_error;
  logic       parity_error;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned assertions = 0;
  int unsigned failures   = 0;
  int unsigned cyc        = 0;
  int unsigned valid_cnt  = 0;
  int unsigned ferr_cnt   = 0;
  int unsigned last_valid_cyc = 0;
  int unsigned start_cyc  = 0;

  uart_receive #(.CLKS_PER_BIT(32'd16)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .UART_RX      (UART_RX),
    .data         (data),
    .valid        (valid),
    .busy         (busy),
    .frame_error  (frame_error),
    .parity_error (parity_error)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Scoreboard monitor: every valid pulse must match the oldest queued byte.
  always @(negedge CLK) begin
    exp_t e;
    if (valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      assertions++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid: got data=%h, required no output", data);
      end else begin
        e = exp_q.pop_front();
        if (data !== e.data || parity_error !== e.perr) begin
          failures++;
          $display("FAIL rx_byte: got data=%h perr=%b, required data=%h perr=%b",
                   data, parity_error, e.data, e.perr);
        end
      end
      assertions++;
      if (frame_error !== 1'b0) begin
        failures++;
        $display("FAIL valid_ferr_exclusive: got frame_error=%b with valid, required 0", frame_error);
      end
    end else if (parity_error) begin
      assertions++;
      failures++;
      $display("FAIL lone_parity_error: got parity_error=1 without valid, required 0");
    end
    if (frame_error) ferr_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input logic v);
    UART_RX = v;
    repeat (CPB) @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    UART_RX = 1'b1;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    exp_t e;
    e.data = b;
    e.perr = 1'b0;
`ifdef UART_RX_PARITY_EN
    e.perr = (par_bit != ^b);
`endif
    if (stop_bit) exp_q.push_back(e);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_bit);
`endif
    drive_bit(stop_bit);
  endtask

  task automatic check_drained(input string name);
    assertions++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drained: got %0d pending bytes, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    RESET   = 1'b0;
    UART_RX = 1'b1;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    assertions += 5;
    if (data !== 8'h00)        begin failures++; $display("FAIL reset_data: got %h, required 00", data); end
    if (valid !== 1'b0)        begin failures++; $display("FAIL reset_valid: got %b, required 0", valid); end
    if (busy !== 1'b0)         begin failures++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (frame_error !== 1'b0)  begin failures++; $display("FAIL reset_ferr: got %b, required 0", frame_error); end
    if (parity_error !== 1'b0) begin failures++; $display("FAIL reset_perr: got %b, required 0", parity_error); end
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    idle(8);
  endtask

  task automatic test_single;
    int unsigned v0;
    int unsigned lat;
    v0 = valid_cnt;
    send_frame(8'hA5, 1'b1, ^8'hA5);
    idle(20);
    lat = last_valid_cyc - start_cyc;
    assertions += 4;
    if (valid_cnt != v0 + 1) begin failures++; $display("FAIL single_valid_count: got %0d, required %0d", valid_cnt - v0, 1); end
    if (data !== 8'hA5)      begin failures++; $display("FAIL single_data: got %h, required a5", data); end
    if (busy !== 1'b0)       begin failures++; $display("FAIL single_busy: got %b, required 0", busy); end
    if (lat + 2 < LATENCY || lat > LATENCY + 2) begin
      failures++;
      $display("FAIL single_latency: got %0d cycles, required %0d +/-2", lat, LATENCY);
    end
    check_drained("single");
  endtask

  task automatic test_back_to_back;
    int unsigned v0;
    v0 = valid_cnt;
    send_frame(8'h00, 1'b1, ^8'h00);
    send_frame(8'hFF, 1'b1, ^8'hFF);
    idle(20);
    assertions += 2;
    if (valid_cnt != v0 + 2) begin failures++; $display("FAIL b2b_valid_count: got %0d, required 2", valid_cnt - v0); end
    if (data !== 8'hFF)      begin failures++; $display("FAIL b2b_data: got %h, required ff", data); end
    check_drained("b2b");
  endtask

  task automatic test_glitch;
    int unsigned v0;
    int unsigned f0;
    logic saw_busy;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    saw_busy = 1'b0;
    UART_RX = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (busy) saw_busy = 1'b1;
      if (i == 3) UART_RX = 1'b1;
    end
    assertions += 4;
    if (saw_busy !== 1'b1)   begin failures++; $display("FAIL glitch_busy_rise: got %b, required 1", saw_busy); end
    if (busy !== 1'b0)       begin failures++; $display("FAIL glitch_busy_fall: got %b, required 0", busy); end
    if (valid_cnt != v0)     begin failures++; $display("FAIL glitch_valid: got %0d pulses, required 0", valid_cnt - v0); end
    if (ferr_cnt != f0)      begin failures++; $display("FAIL glitch_ferr: got %0d pulses, required 0", ferr_cnt - f0); end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_frame_error;
    int unsigned v0;
    int unsigned f0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, ^8'h3C);
    assertions += 3;
    if (ferr_cnt != f0 + 1) begin failures++; $display("FAIL ferr_count: got %0d, required 1", ferr_cnt - f0); end
    if (valid_cnt != v0)    begin failures++; $display("FAIL ferr_valid: got %0d pulses, required 0", valid_cnt - v0); end
    if (data !== 8'hFF)     begin failures++; $display("FAIL ferr_data_held: got %h, required ff", data); end
    UART_RX = 1'b0;
    repeat (40) @(posedge CLK);
    #1;
    idle(CPB);
    send_frame(8'h55, 1'b1, ^8'h55);
    idle(20);
    assertions += 3;
    if (valid_cnt != v0 + 1) begin failures++; $display("FAIL ferr_recover_count: got %0d, required 1", valid_cnt - v0); end
    if (data !== 8'h55)      begin failures++; $display("FAIL ferr_recover_data: got %h, required 55", data); end
    if (ferr_cnt != f0 + 1)  begin failures++; $display("FAIL ferr_after_low: got %0d, required 1", ferr_cnt - f0); end
    check_drained("ferr");
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] b;
    int unsigned v0;
    b = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    UART_RX = b[4];
    repeat (CPB / 2) @(posedge CLK);
    #1;
    assertions++;
    if (busy !== 1'b1) begin failures++; $display("FAIL midreset_busy_before: got %b, required 1", busy); end
    RESET = 1'b0;
    #1;
    assertions += 5;
    if (data !== 8'h00)        begin failures++; $display("FAIL midreset_data: got %h, required 00", data); end
    if (valid !== 1'b0)        begin failures++; $display("FAIL midreset_valid: got %b, required 0", valid); end
    if (busy !== 1'b0)         begin failures++; $display("FAIL midreset_busy: got %b, required 0", busy); end
    if (frame_error !== 1'b0)  begin failures++; $display("FAIL midreset_ferr: got %b, required 0", frame_error); end
    if (parity_error !== 1'b0) begin failures++; $display("FAIL midreset_perr: got %b, required 0", parity_error); end
    UART_RX = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    RESET = 1'b1;
    idle(20);
    v0 = valid_cnt;
    send_frame(8'h81, 1'b1, ^8'h81);
    idle(20);
    assertions += 2;
    if (valid_cnt != v0 + 1) begin failures++; $display("FAIL midreset_next_count: got %0d, required 1", valid_cnt - v0); end
    if (data !== 8'h81)      begin failures++; $display("FAIL midreset_next_data: got %h, required 81", data); end
    check_drained("midreset");
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int unsigned v0;
    v0 = valid_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    idle(20);
    assertions += 2;
    if (valid_cnt != v0 + 1) begin failures++; $display("FAIL parity_count: got %0d, required 1", valid_cnt - v0); end
    if (data !== 8'h07)      begin failures++; $display("FAIL parity_data: got %h, required 07", data); end
    check_drained("parity");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
